// File: rtl/cache_refill_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl_pkg
// Description : Shared cache definitions: default widths, derived address and
//               line sizes, and the refill controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_refill_ctrl_pkg;

    // Default geometry: 32-bit words, 4-word lines, 32 sets, 5-bit tags.
    localparam int DEF_DATA_WIDTH   = 32;
    localparam int DEF_OFFSET_WIDTH = 2;
    localparam int DEF_INDEX_WIDTH  = 5;
    localparam int DEF_TAG_WIDTH    = 5;

    // Word address is {tag, index, offset}.
    function automatic int addr_width(input int tag_w, input int index_w, input int offset_w);
        return tag_w + index_w + offset_w;
    endfunction

    // Number of words in one cache line.
    function automatic int line_width(input int offset_w);
        return 1 << offset_w;
    endfunction

    localparam int DEF_ADDR_WIDTH = addr_width(DEF_TAG_WIDTH, DEF_INDEX_WIDTH, DEF_OFFSET_WIDTH);
    localparam int DEF_LINE_WIDTH = line_width(DEF_OFFSET_WIDTH);

    // Controller state encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LOOKUP  = 2'd1;
    localparam logic [1:0] ST_MEM_REQ = 2'd2;
    localparam logic [1:0] ST_REFILL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        LOOKUP  = ST_LOOKUP,
        MEM_REQ = ST_MEM_REQ,
        REFILL  = ST_REFILL
    } state_e;

endpackage
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : cache_refill_ctrl
// Description : Blocking read controller for a direct-mapped cache. Hits are
//               answered from the store; misses fetch the whole line as a
//               burst, write it into the store and return the requested word.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter  int OFFSET_WIDTH = DEF_OFFSET_WIDTH,
    parameter  int INDEX_WIDTH  = DEF_INDEX_WIDTH,
    parameter  int TAG_WIDTH    = DEF_TAG_WIDTH,
    localparam int ADDR_WIDTH   = addr_width(TAG_WIDTH, INDEX_WIDTH, OFFSET_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    // CPU side
    input  logic                      req_valid,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [DATA_WIDTH-1:0]     resp_data,
    // Cache store lookup
    output logic [INDEX_WIDTH-1:0]    cache_rd_index,
    output logic [OFFSET_WIDTH-1:0]   cache_rd_offset,
    output logic [TAG_WIDTH-1:0]      cache_rd_tag,
    input  logic                      cache_rd_hit,
    input  logic [DATA_WIDTH-1:0]     cache_rd_data,
    // Cache store refill
    output logic [INDEX_WIDTH-1:0]    cache_wr_index,
    output logic [OFFSET_WIDTH-1:0]   cache_wr_offset,
    output logic [TAG_WIDTH-1:0]      cache_wr_tag,
    output logic [DATA_WIDTH-1:0]     cache_wr_data,
    output logic [DATA_WIDTH/8-1:0]   cache_wr_sel,
    output logic                      cache_wr_en,
    output logic                      cache_wr_new,
    // Memory bus
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    input  logic                      mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]     mem_rsp_data
);

    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [OFFSET_WIDTH-1:0] beat_q, beat_d;
    logic                    resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;

    logic [OFFSET_WIDTH-1:0] addr_offset;
    logic [INDEX_WIDTH-1:0]  addr_index;
    logic [TAG_WIDTH-1:0]    addr_tag;

    assign addr_offset = addr_q[OFFSET_WIDTH-1:0];
    assign addr_index  = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign addr_tag    = addr_q[OFFSET_WIDTH+INDEX_WIDTH +: TAG_WIDTH];

    // Store and memory addresses always follow the latched request.
    assign cache_rd_index  = addr_index;
    assign cache_rd_offset = addr_offset;
    assign cache_rd_tag    = addr_tag;
    assign cache_wr_index  = addr_index;
    assign cache_wr_tag    = addr_tag;
    assign cache_wr_offset = beat_q;
    assign cache_wr_data   = mem_rsp_data;
    assign cache_wr_sel    = '1;
    assign mem_req_addr    = {addr_tag, addr_index, {OFFSET_WIDTH{1'b0}}};
    assign resp_valid      = resp_valid_q;
    assign resp_data       = resp_data_q;

    // State, latched address, beat counter and registered response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            beat_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            beat_q       <= beat_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Next-state logic and handshake/write strobes.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        beat_d        = beat_q;
        resp_valid_d  = 1'b0;
        resp_data_d   = resp_data_q;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        cache_wr_en   = 1'b0;
        cache_wr_new  = 1'b0;

        unique case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                if (cache_rd_hit) begin
                    resp_data_d  = cache_rd_data;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    state_d = MEM_REQ;
                end
            end
            MEM_REQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    beat_d  = '0;
                    state_d = REFILL;
                end
            end
            REFILL: begin
                // Idle bus cycles simply hold everything.
                if (mem_rsp_valid) begin
                    cache_wr_en = 1'b1;
                    beat_d      = beat_q + 1'b1;
                    if (beat_q == addr_offset) begin
                        resp_data_d = mem_rsp_data;
                    end
                    // Tag/valid are set only once the full line is written.
                    if (beat_q == LAST_BEAT) begin
                        cache_wr_new = 1'b1;
                        resp_valid_d = 1'b1;
                        state_d      = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
